// File: rtl/rpn_key_cmd_unit_if.sv
// Command handshake between the key front-end and the RPN core.
// Master issues {op, val} under valid; slave accepts with ready.
interface rpn_key_cmd_unit_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_val;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_val,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_val,
        output cmd_ready
    );
endinterface

// File: rtl/rpn_key_cmd_unit.sv
// Key front-end: sync + debounce four buttons, emit one command per press.
// Commands carry {mode, key index} and the operand switches at press time.
module rpn_key_cmd_unit #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 i_key_n,
    input  logic [1:0]                 i_mode,
    input  logic [15:0]                i_val,
    rpn_key_cmd_unit_if.master         cmd,
    output logic                       o_multi_key_err,
    output logic [7:0]                 o_press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HELD
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_s1;
    logic [3:0]  r_s2;
    logic [3:0]  r_s2_prev;
    logic [3:0]  r_stable;
    logic [DB_W-1:0] r_cnt;

    logic [3:0]  r_op;
    logic [15:0] r_val;
    logic [7:0]  r_count;
    logic        r_err;

    logic        w_upd;
    logic        w_from_idle;
    logic [2:0]  w_zeros;
    logic        w_press;
    logic        w_multi;
    logic [1:0]  w_idx;
    logic        w_load;
    logic        w_xfer;

    assign w_zeros     = 3'($countones(~r_s2));
    assign w_upd       = (r_s2 != r_stable) && (r_s2 == r_s2_prev)
                         && (r_cnt == DB_W'(DB_CYCLES - 1));
    assign w_from_idle = w_upd && (r_stable == 4'hF);
    assign w_press     = w_from_idle && (w_zeros == 3'd1);
    assign w_multi     = w_from_idle && (w_zeros >= 3'd2);

    // Two-flop synchronizer on the raw buttons, plus last-cycle copy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 4'hF;
            r_s2      <= 4'hF;
            r_s2_prev <= 4'hF;
        end else begin
            r_s1      <= i_key_n;
            r_s2      <= r_s1;
            r_s2_prev <= r_s2;
        end
    end

    // Debounce: accept s2 once it has held a new value long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 4'hF;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_s2 != r_s2_prev) begin
            r_cnt <= '0;
        end else if (w_upd) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Index of the single pressed key
    always_comb begin
        w_idx = 2'd0;
        case (r_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next state; HELD with all keys up behaves as IDLE so a
    // press landing on that exact cycle is not lost
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_xfer = 1'b0;
        unique case (r_state)
            IDLE, HELD: begin
                if (r_state == IDLE || r_stable == 4'hF) begin
                    w_next = IDLE;
                    if (w_press) begin
                        w_next = PEND;
                        w_load = 1'b1;
                    end else if (w_multi) begin
                        w_next = HELD;
                    end
                end
            end
            PEND: begin
                if (cmd.cmd_ready) begin
                    w_xfer = 1'b1;
                    w_next = HELD;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Command payload, transfer counter and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_val   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_multi;
            if (w_load) begin
                r_op  <= {i_mode, w_idx};
                r_val <= i_val;
            end
            if (w_xfer) r_count <= r_count + 8'd1;
        end
    end

    assign cmd.cmd_valid   = (r_state == PEND);
    assign cmd.cmd_op      = r_op;
    assign cmd.cmd_val     = r_val;
    assign o_multi_key_err = r_err;
    assign o_press_count   = r_count;

endmodule

// File: doc/rpn_key_cmd_unit.md
Name: rpn_key_cmd_unit

Overview:
- Front-end stage directly upstream of the RPN calculator core.
- Synchronizes and debounces the four raw active-low push-buttons, then encodes each clean press with the mode switches into a 4-bit opcode.
- Captures the 16-bit switch value with each command and presents it to the calculator over a valid/ready handshake.
- Replaces ad-hoc key-delay edge detection inside the calculator: one press yields exactly one command.

Parameters:
- DB_CYCLES, 50000, consecutive cycles the synchronized key vector must hold unchanged before it is accepted as stable (≥2; bench uses 4).
- DB_W, 16, width of the debounce counter; must hold DB_CYCLES-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- key_n  in  4  raw push-buttons, active-low, asynchronous to clk
- mode  in  2  mode switches SW17..SW16, quasi-static
- val  in  16  operand switches SW15..SW0, quasi-static
- cmd_ready  in  1  calculator can accept a command this cycle
- cmd_valid  out  1  command pending
- cmd_op  out  4  {mode, key index}; key index = bit position of the single low key
- cmd_val  out  16  val sampled at the press event
- multi_key_err  out  1  one-cycle pulse: more than one key went low together
- press_count  out  8  number of accepted (transferred) commands, wraps

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - cmd_valid=0, cmd_op=0, cmd_val=0, multi_key_err=0, press_count=0.
  - Synchronizer flops = 4'b1111, stable vector = 4'b1111, debounce counter = 0, state IDLE.
- Synchronizer: key_n passes through two flops to give s2; mode and val are used unsynchronized (static switches).
- Debounce, per cycle:
  - s2 == stable: counter cleared.
  - s2 != stable and s2 != previous s2: counter cleared.
  - Otherwise counter increments.
  - When counter == DB_CYCLES-1 and s2 != stable: stable <= s2, counter <= 0.
- Press event (stable_prev == 4'b1111 and the new stable value has exactly one 0), in state IDLE only:
  - cmd_op <= {mode, idx}; cmd_val <= val; cmd_valid <= 1 next cycle; go to PEND.
- Multi-key event: stable leaves 4'b1111 with two or more 0s.
  - multi_key_err pulses 1 cycle; no command issued; go to HELD.
- States:
  - IDLE: waits for a press or multi-key event.
  - PEND: cmd_valid=1; cmd_op and cmd_val held constant while cmd_ready=0. The cycle cmd_valid && cmd_ready: transfer; press_count increments (255 wraps to 0); cmd_valid=0 next cycle; go to HELD.
  - HELD: no new commands; go to IDLE when stable == 4'b1111.
- Latency: with a clean edge on key_n, cmd_valid rises DB_CYCLES+3 cycles after the edge (2 sync + DB_CYCLES debounce + 1 register).
- Boundary conditions:
  - Key released before transfer: command stays pending. After transfer, HELD sees 1111 and returns to IDLE on the next cycle.
  - Release and re-press while in PEND: the second press is dropped (not queued).
  - Additional keys pressed while one is held: ignored; no error pulse.
  - Bounce shorter than DB_CYCLES: never changes stable, so no command.
  - Key held low across reset release: stable starts at 1111, so after debounce this counts as a fresh press and issues one command.
  - rst asserted in PEND: pending command discarded, cmd_valid=0 the next cycle, press_count not incremented.
  - cmd_ready high with cmd_valid low: no effect.

Test Plan (DB_CYCLES=4):
- Clean press: mode=2'b00, val=16'h1234, key_n=4'b0111 held 20 cycles, cmd_ready=1 → exactly one cmd_valid pulse 7 cycles after the edge, cmd_op=4'b0011, cmd_val=16'h1234, press_count=1.
- Bounce: key_n[2] toggles every 2 cycles ×6 then settles low with mode=2'b01 → one command cmd_op=4'b0110; no extra commands during the toggling.
- Backpressure: cmd_ready=0 for 10 cycles after cmd_valid rises; change val to 16'hFFFF and release the key meanwhile → cmd_op and cmd_val stay unchanged; transfer on the first cycle cmd_ready=1; press_count increments once; state returns to IDLE.
- Multi-key: key_n=4'b0101 clean → multi_key_err high exactly 1 cycle, cmd_valid stays 0; after release, a single-key press works normally.
- Wrap and reset: 256 accepted presses → press_count=0. Then press with cmd_ready=0, assert rst for 1 cycle during PEND → cmd_valid=0 the next cycle, press_count=0, no transfer.
- Held through reset: key_n[0]=0 during and after rst → one command cmd_op={mode,2'b00} after debounce, none further until release.
